// File: rtl/fpgart_pkg.sv
// Shared types and default sizing for the brush plotter and its raster scanner.
package fpgart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int DEFAULT_SCREEN_WIDTH  = 320;
  localparam int DEFAULT_SCREEN_HEIGHT = 240;
  localparam int DEFAULT_CELL_SIZE     = 4;
  localparam int DEFAULT_BRUSH_MAX     = 4;
  localparam int DEFAULT_COLOUR_BITS   = 3;
  localparam int DEFAULT_BG_COLOUR     = 0;

  // Coordinate widths match the VGA adapter port widths.
  localparam int X_W = $clog2(DEFAULT_SCREEN_WIDTH) + 1;
  localparam int Y_W = $clog2(DEFAULT_SCREEN_HEIGHT) + 1;

endpackage

// File: rtl/raster_scanner.sv
// Row-major rectangle walker shared by paint strokes and full-screen clears.
module raster_scanner #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          iClk,
  input  logic          iResetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x_last,
  input  logic [YW-1:0] y_last,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] row_x0_q;
  logic [XW-1:0] x_last_q;
  logic [YW-1:0] y_last_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      x_q      <= '0;
      y_q      <= '0;
      row_x0_q <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
    end else if (start) begin
      x_q      <= x0;
      y_q      <= y0;
      row_x0_q <= x0;
      x_last_q <= x_last;
      y_last_q <= y_last;
    end else if (step) begin
      if (x_q == x_last_q) begin
        x_q <= row_x0_q;
        y_q <= y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == x_last_q) && (y_q == y_last_q);

endmodule

// File: rtl/brush_plotter.sv
// Turns mouse cell position and button levels into a ready/valid stream of
// clipped, de-duplicated square brush strokes and full-screen clears.
module brush_plotter
  import fpgart_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int CELL_SIZE     = DEFAULT_CELL_SIZE,
  parameter int BRUSH_MAX     = DEFAULT_BRUSH_MAX,
  parameter int COLOUR_BITS   = DEFAULT_COLOUR_BITS,
  parameter int BG_COLOUR     = DEFAULT_BG_COLOUR
) (
  input  logic                              iClk,
  input  logic                              iResetn,
  input  logic                              iClear,
  input  logic [COLOUR_BITS-1:0]            iColour,
  input  logic [2:0]                        iBrush,
  input  logic [7:0]                        iX_cell,
  input  logic [7:0]                        iY_cell,
  input  logic                              iLeftbtn,
  input  logic                              iRightbtn,
  input  logic                              iReady,
  output logic [$clog2(SCREEN_WIDTH):0]     oX_pixel,
  output logic [$clog2(SCREEN_HEIGHT):0]    oY_pixel,
  output logic [COLOUR_BITS-1:0]            oColour,
  output logic                              oPlot,
  output logic                              oBusy
);

  localparam int XW = $clog2(SCREEN_WIDTH) + 1;
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
  localparam logic [COLOUR_BITS-1:0] BG = COLOUR_BITS'(BG_COLOUR);

  typedef struct packed {
    logic [7:0]             x_cell;
    logic [7:0]             y_cell;
    logic [2:0]             brush;
    logic [COLOUR_BITS-1:0] colour;
  } stroke_t;

  state_t                 state, state_n;
  stroke_t                req, cur_q, rec_q;
  logic                   rec_valid;
  logic [COLOUR_BITS-1:0] colour_q;
  logic                   empty_q;

  logic [2:0]  brush_eff;
  logic [31:0] px0, py0, span, px_end, py_end, px_lim, py_lim;
  logic        off_screen, any_btn, is_dup, step;

  logic          scan_start, sel_clear, load_stroke, rec_write, rec_kill;
  logic [XW-1:0] scan_x0, scan_x_last, scan_x;
  logic [YW-1:0] scan_y0, scan_y_last, scan_y;
  logic          scan_last;

  // Request decode: clamp the brush, pick the stroke colour and clip the
  // rectangle with full-width arithmetic so large cells cannot wrap on-screen.
  always_comb begin
    if (iBrush == 3'd0)                brush_eff = 3'd1;
    else if (32'(iBrush) > BRUSH_MAX)  brush_eff = 3'(BRUSH_MAX);
    else                               brush_eff = iBrush;

    req.x_cell = iX_cell;
    req.y_cell = iY_cell;
    req.brush  = brush_eff;
    req.colour = iLeftbtn ? iColour : BG;

    px0    = 32'(iX_cell) * 32'(CELL_SIZE);
    py0    = 32'(iY_cell) * 32'(CELL_SIZE);
    span   = 32'(brush_eff) * 32'(CELL_SIZE);
    px_end = px0 + span;
    py_end = py0 + span;
    px_lim = (px_end > 32'(SCREEN_WIDTH))  ? 32'(SCREEN_WIDTH)  : px_end;
    py_lim = (py_end > 32'(SCREEN_HEIGHT)) ? 32'(SCREEN_HEIGHT) : py_end;
    off_screen = (px0 >= 32'(SCREEN_WIDTH)) || (py0 >= 32'(SCREEN_HEIGHT));
  end

  assign any_btn = iLeftbtn || iRightbtn;
  assign is_dup  = rec_valid && (req == rec_q);
  assign oPlot   = (state == CLEAR) || ((state == PAINT) && !empty_q);
  assign oBusy   = (state != IDLE);
  assign step    = oPlot && iReady;

  assign scan_x0     = sel_clear ? '0 : XW'(px0);
  assign scan_y0     = sel_clear ? '0 : YW'(py0);
  assign scan_x_last = sel_clear ? XW'(SCREEN_WIDTH - 1)  : XW'(px_lim - 32'd1);
  assign scan_y_last = sel_clear ? YW'(SCREEN_HEIGHT - 1) : YW'(py_lim - 32'd1);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    scan_start  = 1'b0;
    sel_clear   = 1'b0;
    load_stroke = 1'b0;
    rec_write   = 1'b0;
    rec_kill    = 1'b0;
    case (state)
      IDLE: begin
        if (iClear) begin
          state_n    = CLEAR;
          scan_start = 1'b1;
          sel_clear  = 1'b1;
          rec_kill   = 1'b1;
        end else if (any_btn && !is_dup) begin
          state_n     = PAINT;
          scan_start  = 1'b1;
          load_stroke = 1'b1;
        end
      end
      PAINT: begin
        if (iClear) begin
          state_n    = CLEAR;
          scan_start = 1'b1;
          sel_clear  = 1'b1;
          rec_kill   = 1'b1;
        end else if (empty_q || (step && scan_last)) begin
          // An off-screen stroke is recorded too, so a held button does not
          // keep re-triggering empty strokes.
          state_n   = IDLE;
          rec_write = 1'b1;
        end
      end
      CLEAR: begin
        if (step && scan_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state     <= IDLE;
      cur_q     <= '0;
      rec_q     <= '0;
      rec_valid <= 1'b0;
      colour_q  <= '0;
      empty_q   <= 1'b0;
    end else begin
      state <= state_n;

      if (load_stroke) begin
        cur_q    <= req;
        colour_q <= req.colour;
        empty_q  <= off_screen;
      end else if (scan_start) begin
        colour_q <= BG;
        empty_q  <= 1'b0;
      end

      if (rec_kill) begin
        rec_valid <= 1'b0;
      end else if (rec_write) begin
        rec_valid <= 1'b1;
        rec_q     <= cur_q;
      end else if (!any_btn) begin
        rec_valid <= 1'b0;
      end
    end
  end

  raster_scanner #(
    .XW (XW),
    .YW (YW)
  ) u_scanner (
    .iClk    (iClk),
    .iResetn (iResetn),
    .start   (scan_start),
    .x0      (scan_x0),
    .y0      (scan_y0),
    .x_last  (scan_x_last),
    .y_last  (scan_y_last),
    .step    (step),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  assign oX_pixel = scan_x;
  assign oY_pixel = scan_y;
  assign oColour  = colour_q;

endmodule
